// File: rtl/strip_id.sv
// Receive-side tag checker: validates TID/TUSER against the AM header and
// beat count, strips both tags and forwards plain AXIS with optional truncation.
module strip_id #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDEST_WIDTH = 16,
  parameter int TID_WIDTH   = 16,
  parameter int TUSER_WIDTH = 16,
  parameter int TRUNCATE    = 0,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [TDATA_WIDTH-1:0] in_TDATA,
  input  logic                   in_TVALID,
  output logic                   in_TREADY,
  input  logic [TDEST_WIDTH-1:0] in_TDEST,
  input  logic                   in_TLAST,
  input  logic [TKEEP_WIDTH-1:0] in_TKEEP,
  input  logic [TID_WIDTH-1:0]   in_TID,
  input  logic [TUSER_WIDTH-1:0] in_TUSER,
  output logic [TDATA_WIDTH-1:0] out_TDATA,
  output logic                   out_TVALID,
  input  logic                   out_TREADY,
  output logic [TDEST_WIDTH-1:0] out_TDEST,
  output logic                   out_TLAST,
  output logic [TKEEP_WIDTH-1:0] out_TKEEP,
  output logic                   err_id,
  output logic                   err_len,
  output logic [31:0]            pkt_count,
  output logic [15:0]            err_count
);

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [TUSER_WIDTH-1:0] beat;
  logic [TUSER_WIDTH-1:0] len;
  logic [TUSER_WIDTH-1:0] beat_n;
  logic [TUSER_WIDTH-1:0] len_cur;
  logic                   accept;
  logic                   fwd;
  logic                   trunc_hit;
  logic                   id_bad;
  logic                   len_bad;
  logic [16:0]            err_sum;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= HEAD;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HEAD: begin
        if (accept) begin
          if (in_TLAST)       state_n = HEAD;
          else if (trunc_hit) state_n = DROP;
          else                state_n = BODY;
        end
      end
      BODY: begin
        if (accept) begin
          if (in_TLAST)       state_n = HEAD;
          else if (trunc_hit) state_n = DROP;
        end
      end
      DROP: begin
        if (accept && in_TLAST) state_n = HEAD;
      end
      default: state_n = HEAD;
    endcase
  end

  // Header beat restarts the count; body beats saturate instead of wrapping.
  always_comb begin
    in_TREADY = (state == DROP) | ~out_TVALID | out_TREADY;
    accept    = in_TVALID & in_TREADY;
    fwd       = accept & (state != DROP);
    if (state == HEAD) begin
      beat_n  = TUSER_WIDTH'(1);
      len_cur = in_TUSER;
    end else begin
      beat_n  = (&beat) ? beat : beat + TUSER_WIDTH'(1);
      len_cur = len;
    end
    trunc_hit = (TRUNCATE != 0) & ~in_TLAST & (beat_n == len_cur);
    id_bad    = accept & (state == HEAD) &
                (in_TID != in_TDATA[24 +: TID_WIDTH]);
    len_bad   = fwd & (in_TLAST ? (beat_n != len_cur) : trunc_hit);
    err_sum   = {1'b0, err_count} + 17'(err_id) + 17'(err_len);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_TVALID <= 1'b0;
      out_TDATA  <= '0;
      out_TDEST  <= '0;
      out_TLAST  <= 1'b0;
      out_TKEEP  <= '0;
    end else if (fwd) begin
      out_TVALID <= 1'b1;
      out_TDATA  <= in_TDATA;
      out_TDEST  <= in_TDEST;
      out_TLAST  <= in_TLAST | trunc_hit;
      out_TKEEP  <= in_TKEEP;
    end else if (out_TREADY) begin
      out_TVALID <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      beat <= '0;
      len  <= '0;
    end else if (fwd) begin
      beat <= beat_n;
      len  <= len_cur;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      err_id    <= 1'b0;
      err_len   <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      err_id    <= id_bad;
      err_len   <= len_bad;
      if (accept && in_TLAST) pkt_count <= pkt_count + 32'd1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_strip_id.sv
// Randomized bench for strip_id: one plain and one truncating instance share
// the stimulus; a packet-level model predicts forwarded beats and error tallies.
module tb_strip_id;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic [63:0] in_TDATA;
  logic [15:0] in_TDEST;
  logic [15:0] in_TID;
  logic [15:0] in_TUSER;
  logic [7:0]  in_TKEEP;
  logic        in_TLAST;
  logic        v0, v1, rdy0, rdy1;
  logic        out_TREADY;

  logic [63:0] od0, od1;
  logic [15:0] odst0, odst1;
  logic [7:0]  okp0, okp1;
  logic        ol0, ol1, ov0, ov1;
  logic        eid0, eid1, elen0, elen1;
  logic [31:0] pc0, pc1;
  logic [15:0] ec0, ec1;

  strip_id #(
    .TDATA_WIDTH(64), .TDEST_WIDTH(16), .TID_WIDTH(16),
    .TUSER_WIDTH(16), .TRUNCATE(0)
  ) dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_TDATA(in_TDATA), .in_TVALID(v0), .in_TREADY(rdy0),
    .in_TDEST(in_TDEST), .in_TLAST(in_TLAST), .in_TKEEP(in_TKEEP),
    .in_TID(in_TID), .in_TUSER(in_TUSER),
    .out_TDATA(od0), .out_TVALID(ov0), .out_TREADY(out_TREADY),
    .out_TDEST(odst0), .out_TLAST(ol0), .out_TKEEP(okp0),
    .err_id(eid0), .err_len(elen0),
    .pkt_count(pc0), .err_count(ec0)
  );

  strip_id #(
    .TDATA_WIDTH(64), .TDEST_WIDTH(16), .TID_WIDTH(16),
    .TUSER_WIDTH(16), .TRUNCATE(1)
  ) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_TDATA(in_TDATA), .in_TVALID(v1), .in_TREADY(rdy1),
    .in_TDEST(in_TDEST), .in_TLAST(in_TLAST), .in_TKEEP(in_TKEEP),
    .in_TID(in_TID), .in_TUSER(in_TUSER),
    .out_TDATA(od1), .out_TVALID(ov1), .out_TREADY(out_TREADY),
    .out_TDEST(odst1), .out_TLAST(ol1), .out_TKEEP(okp1),
    .err_id(eid1), .err_len(elen1),
    .pkt_count(pc1), .err_count(ec1)
  );

  typedef struct {
    logic [63:0] d;
    logic [15:0] t;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0, e1;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;
  int exp_pkt = 0, exp_eid = 0, exp_elen = 0;
  int n_eid0 = 0, n_eid1 = 0, n_elen0 = 0, n_elen1 = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge ap_clk) begin
    #2;
    if (!ap_rst) begin
      if (ov0 && out_TREADY) begin
        check("d0_avail", 64'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          check("d0_data", od0, e0.d);
          check("d0_ctl", {ol0, okp0, odst0}, {e0.l, e0.k, e0.t});
        end
      end
      if (ov1 && out_TREADY) begin
        check("d1_avail", 64'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          check("d1_data", od1, e1.d);
          check("d1_ctl", {ol1, okp1, odst1}, {e1.l, e1.k, e1.t});
        end
      end
      n_eid0  += int'(eid0);
      n_eid1  += int'(eid1);
      n_elen0 += int'(elen0);
      n_elen1 += int'(elen1);
    end
  end

  task automatic drive_ready();
    case (bp_mode)
      0:       out_TREADY = 1'b1;
      1:       out_TREADY = ~out_TREADY;
      default: out_TREADY = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Called at a negedge; returns at the negedge after both instances took the beat.
  task automatic send_beat(input logic [63:0] d, input logic l,
                           input logic [7:0] k, input logic [15:0] t,
                           input logic [15:0] id, input logic [15:0] u);
    logic a0, a1;
    in_TDATA = d; in_TLAST = l; in_TKEEP = k;
    in_TDEST = t; in_TID = id; in_TUSER = u;
    v0 = 1'b1; v1 = 1'b1;
    for (int c = 0; c < 200 && (v0 || v1); c++) begin
      drive_ready();
      #1;
      a0 = v0 & rdy0;
      a1 = v1 & rdy1;
      @(negedge ap_clk);
      if (a0) v0 = 1'b0;
      if (a1) v1 = 1'b0;
    end
    if (v0 || v1) begin
      check("accept_timeout", {v0, v1}, 0);
      v0 = 1'b0; v1 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      out_TREADY = 1'b1;
      @(negedge ap_clk);
    end
  endtask

  task automatic send_pkt(input int n, input int u, input logic [15:0] id,
                          input logic [15:0] hdr);
    beat_t pk[$];
    beat_t b;
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d[39:24] = hdr;
      b.d = d;
      b.k = 8'($urandom);
      b.t = 16'($urandom);
      b.l = (i == n - 1);
      pk.push_back(b);
      q0.push_back(b);
    end
    if (u >= 1 && n > u) begin
      for (int i = 0; i < u; i++) begin
        b = pk[i];
        b.l = (i == u - 1);
        q1.push_back(b);
      end
    end else begin
      foreach (pk[i]) q1.push_back(pk[i]);
    end
    exp_pkt++;
    if (id != hdr) exp_eid++;
    if (n != u) exp_elen++;
    for (int i = 0; i < n; i++) begin
      send_beat(pk[i].d, pk[i].l, pk[i].k, pk[i].t,
                (i == 0) ? id : 16'($urandom),
                (i == 0) ? 16'(u) : 16'($urandom));
    end
  endtask

  task automatic check_state(input string tag);
    int ecnt;
    idle(6);
    ecnt = (exp_eid + exp_elen > 65535) ? 65535 : exp_eid + exp_elen;
    check({tag, "_q0"}, 64'(q0.size()), 0);
    check({tag, "_q1"}, 64'(q1.size()), 0);
    check({tag, "_pc0"}, pc0, 64'(exp_pkt));
    check({tag, "_pc1"}, pc1, 64'(exp_pkt));
    check({tag, "_ec0"}, ec0, 64'(ecnt));
    check({tag, "_ec1"}, ec1, 64'(ecnt));
    check({tag, "_eid0"}, 64'(n_eid0), 64'(exp_eid));
    check({tag, "_eid1"}, 64'(n_eid1), 64'(exp_eid));
    check({tag, "_elen0"}, 64'(n_elen0), 64'(exp_elen));
    check({tag, "_elen1"}, 64'(n_elen1), 64'(exp_elen));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ov"}, {ov0, ov1}, 0);
    check({tag, "_od"}, od0 | od1, 0);
    check({tag, "_octl"}, {ol0, ol1, okp0, okp1, odst0, odst1}, 0);
    check({tag, "_err"}, {eid0, eid1, elen0, elen1}, 0);
    check({tag, "_pc"}, {pc0, pc1}, 0);
    check({tag, "_ec"}, {ec0, ec1}, 0);
    check({tag, "_rdy"}, {rdy0, rdy1}, 2'b11);
  endtask

  initial begin
    logic [15:0] h;
    logic [63:0] d;
    int n, u;
    in_TDATA = '0; in_TDEST = '0; in_TID = '0; in_TUSER = '0;
    in_TKEEP = '0; in_TLAST = 1'b0;
    v0 = 1'b0; v1 = 1'b0; out_TREADY = 1'b1;
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    check_reset("rst0");

    bp_mode = 0;
    send_pkt(4, 4, 16'h0012, 16'h0012);
    check_state("t1");
    send_pkt(1, 1, 16'h0005, 16'h0006);
    check_state("t2");
    send_pkt(6, 4, 16'h0031, 16'h0031);
    check_state("t34");
    send_pkt(3, 1, 16'h0040, 16'h0040);
    send_pkt(1, 0, 16'h0041, 16'h0041);
    send_pkt(2, 5, 16'h0042, 16'h0099);
    check_state("edge");

    bp_mode = 1;
    for (int i = 0; i < 8; i++) begin
      h = 16'($urandom);
      send_pkt(2, 2, h, h);
    end
    check_state("t5");

    for (int i = 0; i < 40; i++) begin
      bp_mode = $urandom_range(0, 2);
      n = $urandom_range(1, 6);
      u = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      h = 16'($urandom);
      send_pkt(n, u, ($urandom_range(0, 3) == 0) ? 16'($urandom) : h, h);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    check_state("rand");

    bp_mode = 0;
    d = {$urandom, $urandom};
    d[39:24] = 16'h0077;
    e0.d = d; e0.k = 8'hFF; e0.t = 16'h0003; e0.l = 1'b0;
    q0.push_back(e0);
    q1.push_back(e0);
    send_beat(d, 1'b0, 8'hFF, 16'h0003, 16'h0077, 16'd5);
    send_beat({$urandom, $urandom}, 1'b0, 8'hFF, 16'h0003, 16'h0, 16'h0);
    out_TREADY = 1'b0;
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    check_reset("rst1");
    check("t6_q0", 64'(q0.size()), 0);
    check("t6_q1", 64'(q1.size()), 0);
    exp_pkt = 0; exp_eid = 0; exp_elen = 0;
    n_eid0 = 0; n_eid1 = 0; n_elen0 = 0; n_elen1 = 0;
    send_pkt(3, 3, 16'h0123, 16'h0123);
    check_state("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
